// File: rtl/if_id_queue_if.sv
// Fetch-to-decode queue bus: fetch push side, decode valid/ready side and occupancy.
// master drives the queue (fetch/decode/redirect logic); slave is the queue itself.
interface if_id_queue_if #(
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          if_valid;
    logic [31:0]   if_pc;
    logic [31:0]   if_pc_p4;
    logic [31:0]   if_instr;
    logic          if_stall;
    logic          flush;
    logic          id_valid;
    logic          id_ready;
    logic [31:0]   id_pc;
    logic [31:0]   id_pc_p4;
    logic [31:0]   id_instr;
    logic [CW-1:0] count;

    modport master (
        output if_valid, if_pc, if_pc_p4, if_instr, flush, id_ready,
        input  if_stall, id_valid, id_pc, id_pc_p4, id_instr, count
    );

    modport slave (
        input  if_valid, if_pc, if_pc_p4, if_instr, flush, id_ready,
        output if_stall, id_valid, id_pc, id_pc_p4, id_instr, count
    );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: DEPTH-entry FWFT FIFO of {pc, pc+4, instr} with
// full-stall to fetch, valid/ready to decode and whole-queue flush on redirect.
module if_id_queue #(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst,
    if_id_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_p4;
        logic [31:0] instr;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full, empty, push, pop;
    entry_t          head;

    // Flags depend only on the registered count, so if_stall has no input path.
    always_comb begin
        full  = (count_q == CW'(DEPTH));
        empty = (count_q == '0);
        push  = bus.if_valid && !full && !bus.flush;
        pop   = !empty && bus.id_ready && !bus.flush;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{pc: bus.if_pc, pc_p4: bus.if_pc_p4, instr: bus.if_instr};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !push)
            count_d = count_q - CW'(1);
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        head = mem_q[rd_ptr_q];
        if (empty)
            head = '{pc: 32'h0, pc_p4: 32'h0, instr: NOP_INSTR};
    end

    assign bus.if_stall = full;
    assign bus.id_valid = !empty;
    assign bus.id_pc    = head.pc;
    assign bus.id_pc_p4 = head.pc_p4;
    assign bus.id_instr = head.instr;
    assign bus.count    = count_q;
endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed scenarios with literal checks, then random
// traffic, all outputs compared every cycle against a queue-based model.
module tb_if_id_queue;
    localparam int          DEPTH = 2;
    localparam int          CW    = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;
    bit   chk_en = 1'b0;

    logic [95:0] model_q [$];

    if_id_queue_if #(.DEPTH(DEPTH)) bus ();

    if_id_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference: occupancy is the queue length; flags and head follow from it.
    always @(posedge clk) begin
        bit pushed, popped;
        if (rst || bus.flush) begin
            model_q.delete();
        end else begin
            popped = (model_q.size() > 0) && bus.id_ready;
            pushed = bus.if_valid && (model_q.size() < DEPTH);
            if (popped) void'(model_q.pop_front());
            if (pushed) model_q.push_back({bus.if_pc, bus.if_pc_p4, bus.if_instr});
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [95:0] exp_head;
            exp_head = (model_q.size() > 0) ? model_q[0] : {32'h0, 32'h0, NOP};
            check("count",    32'(bus.count),    32'(model_q.size()));
            check("id_valid", 32'(bus.id_valid), 32'(model_q.size() > 0));
            check("if_stall", 32'(bus.if_stall), 32'(model_q.size() == DEPTH));
            check("id_pc",    bus.id_pc,         exp_head[95:64]);
            check("id_pc_p4", bus.id_pc_p4,      exp_head[63:32]);
            check("id_instr", bus.id_instr,      exp_head[31:0]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr);
        bus.if_valid = v;
        bus.if_pc    = pc;
        bus.if_pc_p4 = pc + 32'd4;
        bus.if_instr = instr;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        bus.flush    = 1'b0;
        bus.id_ready = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;

        // reset / idle
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_valid", 32'(bus.id_valid), 32'd0);
        check("rst_stall", 32'(bus.if_stall), 32'd0);
        check("rst_instr", bus.id_instr, NOP);
        check("rst_pc", bus.id_pc, 32'h0);

        // fill to full
        drive(1'b1, 32'h00, 32'hAAAA_0001);
        step();
        check("fill1_count", 32'(bus.count), 32'd1);
        check("fill1_stall", 32'(bus.if_stall), 32'd0);
        drive(1'b1, 32'h04, 32'hAAAA_0002);
        step();
        check("fill2_count", 32'(bus.count), 32'd2);
        check("fill2_stall", 32'(bus.if_stall), 32'd1);
        drive(1'b1, 32'h08, 32'hAAAA_0003);
        step();
        step();
        check("full_count", 32'(bus.count), 32'd2);
        check("full_head_pc", bus.id_pc, 32'h00);
        check("full_head_p4", bus.id_pc_p4, 32'h04);
        check("full_head_instr", bus.id_instr, 32'hAAAA_0001);

        // drain in order
        drive(1'b0, 32'h0, 32'h0);
        bus.id_ready = 1'b1;
        step();
        check("drain1_count", 32'(bus.count), 32'd1);
        check("drain1_pc", bus.id_pc, 32'h04);
        check("drain1_instr", bus.id_instr, 32'hAAAA_0002);
        step();
        check("drain2_count", 32'(bus.count), 32'd0);
        check("drain2_valid", 32'(bus.id_valid), 32'd0);
        check("drain2_instr", bus.id_instr, NOP);
        bus.id_ready = 1'b0;

        // simultaneous push/pop across the pointer wrap
        drive(1'b1, 32'h0C, 32'hBBBB_000C);
        step();
        bus.id_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("stream_head", bus.id_pc, 32'h0C + 32'(4 * i));
            drive(1'b1, 32'h10 + 32'(4 * i), 32'hBBBB_0010 + 32'(i));
            step();
            check("stream_count", 32'(bus.count), 32'd1);
        end
        check("stream_last", bus.id_pc, 32'h24);
        drive(1'b0, 32'h0, 32'h0);
        step();
        check("stream_empty", 32'(bus.count), 32'd0);

        // flush while full
        bus.id_ready = 1'b0;
        drive(1'b1, 32'h40, 32'hCCCC_0040);
        step();
        drive(1'b1, 32'h44, 32'hCCCC_0044);
        step();
        check("pre_flush_count", 32'(bus.count), 32'd2);
        drive(1'b1, 32'h48, 32'hCCCC_0048);
        bus.id_ready = 1'b1;
        bus.flush    = 1'b1;
        step();
        bus.flush    = 1'b0;
        bus.id_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        check("flush_count", 32'(bus.count), 32'd0);
        check("flush_valid", 32'(bus.id_valid), 32'd0);
        check("flush_stall", 32'(bus.if_stall), 32'd0);
        step();
        check("flush_hold", 32'(bus.count), 32'd0);

        // reset mid-operation
        drive(1'b1, 32'h50, 32'hDDDD_0050);
        step();
        check("mid_count", 32'(bus.count), 32'd1);
        rst = 1'b1;
        drive(1'b1, 32'h54, 32'hDDDD_0054);
        step();
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        check("mrst_count", 32'(bus.count), 32'd0);
        check("mrst_valid", 32'(bus.id_valid), 32'd0);
        step();
        check("mrst_instr", bus.id_instr, NOP);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 3) != 0), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom);
            bus.id_ready = 1'($urandom_range(0, 2) != 0);
            bus.flush    = ($urandom_range(0, 31) == 0);
            rst          = ($urandom_range(0, 127) == 0);
            step();
        end
        rst = 1'b0;
        bus.flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        step();
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Instruction queue between the fetch stage and the decode stage. It buffers fetched {pc, pc+4, instr} triples in a DEPTH-entry first-word-fall-through (FWFT) FIFO.
- It raises if_stall to fetch when it has no free entry.
- It presents a valid/ready interface to decode.
- It discards all queued contents on a control-flow redirect (flush).

Parameters:
- DEPTH, 2, number of queue entries; power of two, minimum 2.
- NOP_INSTR, 32'h00000013, instruction driven on id_instr while the queue is empty (addi x0,x0,0).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- if_valid  input  1  fetch presents a new instruction this cycle.
- if_pc  input  32  PC of the fetched instruction.
- if_pc_p4  input  32  PC+4 of the fetched instruction.
- if_instr  input  32  fetched instruction word.
- if_stall  output  1  queue full; fetch must hold its PC.
- flush  input  1  redirect taken; drop all entries and this cycle's push.
- id_valid  output  1  head entry is valid.
- id_ready  input  1  decode consumes the head this cycle.
- id_pc  output  32  head entry PC.
- id_pc_p4  output  32  head entry PC+4.
- id_instr  output  32  head entry instruction; NOP_INSTR when empty.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage and pointers:
  - Storage: DEPTH entries of 96 bits {pc, pc_p4, instr}.
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap modulo DEPTH naturally.
  - count is a separate registered counter.
- Reset: when rst=1 at a clock edge:
  - wr_ptr=0, rd_ptr=0, count=0.
  - Hence id_valid=0, if_stall=0, id_pc=0, id_pc_p4=0, id_instr=NOP_INSTR.
  - rst overrides flush, push and pop.
  - Storage contents are not reset.
- Full, stall and valid flags are all derived from the registered count:
  - full = (count==DEPTH); empty = (count==0).
  - if_stall = full. It is combinational from the register only, with no path from if_valid, id_ready or flush.
  - id_valid = !empty.
- Push: push = if_valid && !full && !flush.
  - On push, the entry at wr_ptr is written with {if_pc, if_pc_p4, if_instr} and wr_ptr increments.
  - When full, if_valid is ignored; the entry is not lost, because fetch is stalled and re-presents the same instruction.
- Pop: pop = id_valid && id_ready && !flush. On pop, rd_ptr increments.
- Count update:
  - push&&!pop: count+1.
  - pop&&!push: count-1.
  - Both or neither: unchanged.
- Simultaneous push and pop:
  - Allowed at any non-full, non-empty occupancy.
  - At count==DEPTH only pop occurs; push is blocked and the entry is accepted the following cycle.
  - At count==0 only push occurs. There is no bypass: the new entry appears on id_* the cycle after the push.
- Latency: one cycle from accepted push to id_valid / head visible.
- Head outputs (FWFT):
  - id_pc, id_pc_p4 and id_instr are read combinationally from the entry at rd_ptr when non-empty.
  - When empty, they read id_pc=0, id_pc_p4=0, id_instr=NOP_INSTR.
- Flush: when flush=1 at a clock edge (and rst=0):
  - wr_ptr=rd_ptr=0, count=0.
  - The push and pop of that cycle are suppressed.
  - Next cycle: id_valid=0, if_stall=0.
  - Flush on an empty queue has no effect other than pointer reset.
  - Flush and a full queue in the same cycle: the flush wins and the queue is empty next cycle.
- Pointer wrap: pointers wrap from DEPTH-1 to 0 with no special handling. Order is strictly FIFO across the wrap.
- Upstream contract: fetch asserts if_valid only in cycles where its PC will advance at the next edge when not stalled. This includes deasserting if_valid in the hold cycle after fetch reset. if_valid is therefore asserted once per distinct fetched PC.
- id_ready has no effect while id_valid=0.

Test Plan:
- Reset, then idle: rst high 2 cycles, all inputs 0 -> count=0, id_valid=0, if_stall=0, id_instr=32'h00000013, id_pc=0.
- Fill to full (DEPTH=2):
  - Stimulus: id_ready=0; push pc=0x00 instr=0xAAAA0001, then pc=0x04 instr=0xAAAA0002, then hold if_valid=1 with pc=0x08.
  - Response: count 1, then 2; if_stall=1 from the cycle after the second push; the third entry is not written; head stays pc=0x00, id_pc_p4=0x04.
- Drain in order: from full, id_ready=1 for 2 cycles with if_valid=0 -> heads pc=0x00 then 0x04; count 2, 1, 0; id_valid=0 and id_instr=NOP afterward.
- Simultaneous push and pop with wrap:
  - Stimulus: at count=1, stream 6 instructions pc=0x10..0x24 with id_ready=1 every cycle.
  - Response: count stays 1; decode sees pcs in order across the pointer wrap; no drops or duplicates.
- Flush while full: at count=2 with if_valid=1 and id_ready=1, assert flush one cycle -> next cycle count=0, id_valid=0, if_stall=0; neither the incoming instruction nor the popped head is retained or counted.
- Reset mid-operation: at count=1 assert rst together with if_valid=1 and flush=0 -> next cycle count=0, id_valid=0; the pushed entry is not visible after rst deasserts.
